a_muxn_pipe: RTL and testbench
==============================

Name: a_muxn_pipe

Overview:
- Parametrised, registered N-channel, W-bit result/operand select stage for the pipelined ARM datapath.
- Generalises the fixed 1-bit 4:1 select to NCH channels of WIDTH bits each.
- Adds per-channel valid/ready handshake, a one-entry output pipeline register, and two arbitration modes: directed select and round-robin.
- Sits between the ALU/forwarding sources and the next pipeline stage.

Parameters:
- WIDTH, 64, data bits per channel.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH), width of the select and channel-ID fields.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*WIDTH  packed channel data; channel i = in_data[i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- mode  input  1  0 = directed (use sel), 1 = round-robin.
- sel  input  SELW  directed-mode channel select.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  registered index of the channel that produced out_data.
- out_valid  output  1  output register holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- sel_err  output  1  registered one-cycle pulse on an out-of-range sel.

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=0. All in_ready=0 while reset is held. A reset asserted mid-transfer discards the held beat.
- Acceptance condition: load = !out_valid || out_ready. This gives full throughput: one beat per cycle while downstream is ready.
- Grant is combinational and one-hot (or zero):
  - Directed mode: grant[sel] = in_valid[sel] when sel < NCH. Otherwise no grant.
  - Round-robin mode: grant the first channel with in_valid set, scanning rr_ptr, rr_ptr+1, … and wrapping modulo NCH. No grant if no channel is valid.
- Handshake: in_ready[i] = load && grant[i], so at most one in_ready is high per cycle. A transfer on channel i happens when in_valid[i] && in_ready[i].
- On a transfer, at the next clock edge:
  - out_data <= channel data;
  - out_ch <= i;
  - out_valid <= 1.
  - In round-robin mode, rr_ptr <= (i+1) mod NCH. Wrap: granting NCH-1 sets rr_ptr to 0.
- If load is high and there is no transfer: out_valid <= 0. out_data and out_ch keep their old values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid are held stable, all in_ready=0, and rr_ptr is unchanged.
- Latency: exactly 1 cycle from input transfer to out_valid.
- rr_ptr updates only on round-robin transfers. Directed-mode transfers and mode switches leave rr_ptr unchanged, so a switch back to round-robin resumes from the stored pointer.
- sel_err: on the next edge, sel_err <= (mode==0 && sel>=NCH). It is independent of in_valid and stall, and clears the following cycle unless the condition persists. Unreachable when NCH is a power of two.
- mode and sel are sampled combinationally each cycle. A change takes effect in the same cycle's grant. Changing them during a stall has no effect on the held beat.
- Simultaneous out_ready and a new transfer: the held beat is consumed and the new beat is loaded on the same edge. No bubble.
- in_valid deasserted without a handshake: the block neither requires nor checks that valid stays high.

Test Plan:
- Reset/idle: hold reset_n=0 with random inputs -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Deassert reset with in_valid=0 -> outputs stay 0.
- Directed streaming: mode=0, sel=2, in_valid=4'b1111, ch2=64'hA5A5_0000_0000_0002, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=64'hA5A5_0000_0000_0002, out_ch=2. Repeat every cycle with no bubbles.
- Back-pressure: after a beat is loaded, set out_ready=0 for 3 cycles -> out_data/out_ch/out_valid stable, in_ready=0. Raise out_ready with a new beat on ch1 -> ch1 data appears on the next edge.
- Round-robin fairness/wrap: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1001 -> 0,3,0,3.
- Mode switch pointer retention: round-robin grants ch1, switch to directed sel=3 for 2 beats, return to round-robin with all valid -> next grant is ch2.
- Out-of-range select (NCH=3, SELW=2): mode=0, sel=3, in_valid=3'b111 -> in_ready=0, no transfer, sel_err=1 for one cycle per cycle of persistence. Reset asserted mid-stall clears out_valid immediately.

Source files
------------

// File: rtl/a_muxn_pipe.sv
// a_muxn_pipe: registered N-channel select stage with per-channel valid/ready,
// directed or round-robin arbitration and a one-entry output register.
module a_muxn_pipe #(
    parameter int WIDTH = 64,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    logic [WIDTH-1:0] outData_q;
    logic [SELW-1:0]  outCh_q;
    logic             outValid_q;
    logic             selErr_q;
    logic [SELW-1:0]  rrPtr_q;
    logic [SELW-1:0]  rrPtr_d;

    logic             load;
    logic             selInRange;
    logic             grantAny;
    logic [SELW-1:0]  grantIdx;
    logic [WIDTH-1:0] grantData;
    logic             xfer;

    assign load       = !outValid_q || out_ready;
    assign selInRange = (int'(sel) < NCH);
    assign xfer       = reset_n && load && grantAny;

    // Round-robin scans downward so the lowest offset from rrPtr_q wins.
    always_comb begin
        int              c;
        logic [SELW-1:0] cIdx;
        grantAny = 1'b0;
        grantIdx = '0;
        c        = 0;
        cIdx     = '0;
        if (!mode) begin
            if (selInRange && in_valid[sel]) begin
                grantAny = 1'b1;
                grantIdx = sel;
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                c = int'(rrPtr_q) + k;
                if (c >= NCH) begin
                    c = c - NCH;
                end
                cIdx = SELW'(c);
                if (in_valid[cIdx]) begin
                    grantAny = 1'b1;
                    grantIdx = cIdx;
                end
            end
        end
    end

    always_comb begin
        grantData = '0;
        in_ready  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grantIdx == SELW'(i)) begin
                grantData   = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
        rrPtr_d = (grantIdx == SELW'(NCH - 1)) ? '0 : grantIdx + SELW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
            selErr_q   <= 1'b0;
            rrPtr_q    <= '0;
        end else begin
            selErr_q <= !mode && !selInRange;
            if (load) begin
                if (xfer) begin
                    outData_q  <= grantData;
                    outCh_q    <= grantIdx;
                    outValid_q <= 1'b1;
                    if (mode) begin
                        rrPtr_q <= rrPtr_d;
                    end
                end else begin
                    outValid_q <= 1'b0;
                end
            end
        end
    end

    assign out_data  = outData_q;
    assign out_ch    = outCh_q;
    assign out_valid = outValid_q;
    assign sel_err   = selErr_q;

endmodule

// File: tb/tb_a_muxn_pipe.sv
// Bench for a_muxn_pipe: scoreboarded directed steps on a 4-channel instance,
// plus a 3-channel instance for the out-of-range select case.
module tb_a_muxn_pipe;

    localparam int WIDTH = 64;
    localparam int NCH   = 4;
    localparam int SELW  = 2;
    localparam int NCHB  = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NCH*WIDTH-1:0] inData;
    logic [NCH-1:0]       inValid;
    logic [NCH-1:0]       inReady;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     outData;
    logic [SELW-1:0]      outCh;
    logic                 outValid;
    logic                 outReady;
    logic                 selErr;

    logic [NCHB*WIDTH-1:0] bInData;
    logic [NCHB-1:0]       bInValid;
    logic [NCHB-1:0]       bInReady;
    logic                  bMode;
    logic [SELW-1:0]       bSel;
    logic [WIDTH-1:0]      bOutData;
    logic [SELW-1:0]       bOutCh;
    logic                  bOutValid;
    logic                  bOutReady;
    logic                  bSelErr;

    a_muxn_pipe #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
        .in_ready(inReady), .mode(mode), .sel(sel), .out_data(outData),
        .out_ch(outCh), .out_valid(outValid), .out_ready(outReady), .sel_err(selErr)
    );

    a_muxn_pipe #(.WIDTH(WIDTH), .NCH(NCHB)) dutB (
        .clk(clk), .reset_n(reset_n), .in_data(bInData), .in_valid(bInValid),
        .in_ready(bInReady), .mode(bMode), .sel(bSel), .out_data(bOutData),
        .out_ch(bOutCh), .out_valid(bOutValid), .out_ready(bOutReady), .sel_err(bSelErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SELW-1:0]  ch;
    } beat_t;

    int              compared   = 0;
    int              mismatched = 0;
    beat_t           sb[$];
    int              obsCh[$];
    logic            mValid;
    logic            mErr;
    logic [SELW-1:0] mPtr;
    int              beatNo;

    // Every comparison funnels through here so the counters stay in one place.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference arbitration: who should be granted given the current inputs.
    function automatic logic [NCH-1:0] modelGrant(input logic m, input logic [SELW-1:0] s,
                                                  input logic [NCH-1:0] v, input logic [SELW-1:0] p);
        logic [NCH-1:0] g;
        g = '0;
        if (!m) begin
            if (int'(s) < NCH && v[s]) g[s] = 1'b1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (int'(p) + k) % NCH;
                if (v[c]) begin
                    g[c] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] chData(input int ch, input int beat);
        return {16'hA5A5, 16'(beat), 32'(ch)};
    endfunction

    task automatic modelReset();
        mValid = 1'b0;
        mErr   = 1'b0;
        mPtr   = '0;
        beatNo = 0;
        sb.delete();
    endtask

    // One cycle on the 4-channel instance: drive, check registered outputs
    // against the scoreboard, predict the transfer and advance the model.
    task automatic applyStimulus(input logic m, input logic [SELW-1:0] s,
                                 input logic [NCH-1:0] v, input logic r);
        logic           load;
        logic [NCH-1:0] g;
        beat_t          b;
        @(negedge clk);
        mode     = m;
        sel      = s;
        inValid  = v;
        outReady = r;
        for (int i = 0; i < NCH; i++) inData[i*WIDTH +: WIDTH] = chData(i, beatNo);
        #1;
        load = !mValid || r;
        g    = load ? modelGrant(m, s, v, mPtr) : '0;
        checkOutput("in_ready", 64'(inReady), 64'(g));
        if (mValid) begin
            checkOutput("out_valid", 64'(outValid), 64'd1);
            if (sb.size() > 0) begin
                checkOutput("out_data", outData, sb[0].data);
                checkOutput("out_ch", 64'(outCh), 64'(sb[0].ch));
                if (r) begin
                    obsCh.push_back(int'(outCh));
                    void'(sb.pop_front());
                end
            end
        end else begin
            checkOutput("out_valid", 64'(outValid), 64'd0);
        end
        checkOutput("sel_err", 64'(selErr), 64'(mErr));
        mErr = !m && (int'(s) >= NCH);
        if (load) begin
            if (g != '0) begin
                for (int i = 0; i < NCH; i++) begin
                    if (g[i]) begin
                        b.data = chData(i, beatNo);
                        b.ch   = SELW'(i);
                        sb.push_back(b);
                        if (m) mPtr = SELW'((i + 1) % NCH);
                    end
                end
                mValid = 1'b1;
            end else begin
                mValid = 1'b0;
            end
        end
        beatNo++;
    endtask

    initial begin
        int rrExp[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3, 0, 3};
        int swExp[4]  = '{1, 3, 3, 2};

        // Reset held with random inputs on both instances.
        reset_n   = 1'b0;
        bMode     = 1'b0;
        bSel      = '0;
        bInValid  = '0;
        bOutReady = 1'b1;
        for (int i = 0; i < NCHB; i++) bInData[i*WIDTH +: WIDTH] = {16'hB0B0, 48'(i)};
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            inValid  = NCH'($urandom);
            mode     = 1'($urandom);
            sel      = SELW'($urandom);
            outReady = 1'($urandom);
            for (int i = 0; i < NCH; i++) inData[i*WIDTH +: WIDTH] = {$urandom, $urandom};
            bInValid = NCHB'($urandom);
            #1;
            checkOutput("rst_in_ready", 64'(inReady), 64'd0);
            checkOutput("rst_out_valid", 64'(outValid), 64'd0);
            checkOutput("rst_out_data", outData, 64'd0);
            checkOutput("rst_out_ch", 64'(outCh), 64'd0);
            checkOutput("rst_sel_err", 64'(selErr), 64'd0);
            checkOutput("rst_b_in_ready", 64'(bInReady), 64'd0);
        end
        @(negedge clk);
        inValid  = '0;
        bInValid = '0;
        mode     = 1'b0;
        sel      = '0;
        outReady = 1'b1;
        reset_n  = 1'b1;
        modelReset();
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 2'd0, 4'b0000, 1'b1);
        checkOutput("idle_out_data", outData, 64'd0);

        // Directed streaming from channel 2, one beat per cycle.
        beatNo = 0;
        repeat (4) applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
        checkOutput("dir_first_data", obsCh.size() > 0 ? 64'(obsCh[0]) : 64'hDEAD, 64'd2);

        // Back-pressure for three cycles, then a channel-1 beat.
        repeat (3) applyStimulus(1'b0, 2'd2, 4'b1111, 1'b0);
        applyStimulus(1'b0, 2'd1, 4'b1111, 1'b1);
        applyStimulus(1'b0, 2'd1, 4'b0000, 1'b1);

        // Round-robin fairness and wrap.
        obsCh.delete();
        repeat (8) applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        repeat (4) applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        checkOutput("rr_count", 64'(obsCh.size()), 64'd12);
        for (int i = 0; i < 12 && i < obsCh.size(); i++)
            checkOutput($sformatf("rr_seq%0d", i), 64'(obsCh[i]), 64'(rrExp[i]));

        // Pointer retention across a directed interlude.
        obsCh.delete();
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
        repeat (2) applyStimulus(1'b0, 2'd3, 4'b1111, 1'b1);
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        checkOutput("sw_count", 64'(obsCh.size()), 64'd4);
        for (int i = 0; i < 4 && i < obsCh.size(); i++)
            checkOutput($sformatf("sw_seq%0d", i), 64'(obsCh[i]), 64'(swExp[i]));

        // Out-of-range select on the 3-channel instance.
        @(negedge clk);
        bMode    = 1'b0;
        bSel     = 2'd3;
        bInValid = 3'b111;
        #1;
        checkOutput("b_oor_in_ready", 64'(bInReady), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("b_sel_err_1", 64'(bSelErr), 64'd1);
        checkOutput("b_oor_out_valid", 64'(bOutValid), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("b_sel_err_2", 64'(bSelErr), 64'd1);
        bSel = 2'd1;
        #1;
        checkOutput("b_in_ready_ch1", 64'(bInReady), 64'b010);
        @(negedge clk);
        #1;
        bInValid = '0;
        checkOutput("b_sel_err_clr", 64'(bSelErr), 64'd0);
        checkOutput("b_out_valid", 64'(bOutValid), 64'd1);
        checkOutput("b_out_ch", 64'(bOutCh), 64'd1);
        checkOutput("b_out_data", bOutData, {16'hB0B0, 48'd1});

        // Reset in the middle of a stall drops the held beat at once.
        applyStimulus(1'b0, 2'd0, 4'b1111, 1'b1);
        applyStimulus(1'b0, 2'd0, 4'b1111, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("stall_out_valid", 64'(outValid), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
        checkOutput("midrst_out_data", outData, 64'd0);
        checkOutput("midrst_in_ready", 64'(inReady), 64'd0);
        checkOutput("midrst_b_out_valid", 64'(bOutValid), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
